// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, MEM-stage branch
// flushes and variable-latency data memory waits with a bounded timeout.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idex_memread,
    input  logic [4:0]       idex_rt,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_memrd,
    input  logic             exmem_memwr,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             pc_src,
    output logic             mem_wait,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] TIMEOUT_V = WCW'(MEM_TIMEOUT);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic [WCW-1:0]   r_waitCnt;
    logic [WCW-1:0]   w_waitCntNext;
    logic             r_memErr;
    logic             w_memErrNext;
    logic             r_luPrev;
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushEvents;

    logic w_memReq;
    logic w_freeze;
    logic w_timedOut;
    logic w_branch;
    logic w_loadUse;
    logic w_rawMatch;

    assign w_memReq   = exmem_memrd | exmem_memwr;
    assign w_rawMatch = (idex_rt == ifid_rs) | (idex_rt == ifid_rt);

    // Event priority: freeze beats branch beats load-use; deferred events re-appear once MEM advances.
    assign w_freeze   = ((r_state == ST_RUN)  & w_memReq & ~mem_ready) |
                        ((r_state == ST_WAIT) & ~mem_ready & (r_waitCnt < TIMEOUT_V));
    assign w_timedOut = (r_state == ST_WAIT) & ~mem_ready & (r_waitCnt >= TIMEOUT_V);
    assign w_branch   = ~w_freeze & exmem_branch & exmem_zero;
    assign w_loadUse  = ~w_freeze & ~w_branch & ~r_luPrev & idex_memread &
                        (idex_rt != 5'd0) & w_rawMatch;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_src      = 1'b0;
        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else if (w_freeze) begin
            // Everything up to MEM holds; WB gets a bubble so the stalled access is not retired twice.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (w_branch) begin
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else if (w_loadUse) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_comb begin
        w_stateNext   = r_state;
        w_waitCntNext = r_waitCnt;
        w_memErrNext  = r_memErr;
        case (r_state)
            ST_RUN: begin
                if (w_freeze) begin
                    w_stateNext   = ST_WAIT;
                    w_waitCntNext = WCW'(1);
                end
            end
            ST_WAIT: begin
                if (w_freeze) begin
                    w_waitCntNext = r_waitCnt + 1'b1;
                end else begin
                    w_stateNext   = ST_RUN;
                    w_waitCntNext = '0;
                    if (w_timedOut) begin
                        w_memErrNext = 1'b1;
                    end
                end
            end
            default: begin
                w_stateNext   = ST_RUN;
                w_waitCntNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_waitCnt     <= '0;
            r_memErr      <= 1'b0;
            r_luPrev      <= 1'b0;
            r_stallCycles <= '0;
            r_flushEvents <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitCntNext;
            r_memErr  <= w_memErrNext;
            // A load-use bubble is one cycle only; the next cycle proceeds even if inputs still match.
            r_luPrev  <= w_loadUse;
            if (!pc_en && (r_stallCycles != {CNT_W{1'b1}})) begin
                r_stallCycles <= r_stallCycles + 1'b1;
            end
            if (w_branch && (r_flushEvents != {CNT_W{1'b1}})) begin
                r_flushEvents <= r_flushEvents + 1'b1;
            end
        end
    end

    assign mem_wait     = (r_state == ST_WAIT);
    assign mem_err      = r_memErr;
    assign stall_cycles = r_stallCycles;
    assign flush_events = r_flushEvents;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// random traffic, all compared against a cycle-level reference model of the hazard rules.
module tb_pipe_hazard_ctrl;

    localparam int T     = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          idex_memread;
    logic [4:0]    idex_rt;
    logic [4:0]    ifid_rs;
    logic [4:0]    ifid_rt;
    logic          exmem_branch;
    logic          exmem_zero;
    logic          exmem_memrd;
    logic          exmem_memwr;
    logic          mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_src;
    logic          mem_wait, mem_err;
    logic [CW-1:0] stall_cycles, flush_events;

    int nChecks   = 0;
    int nFailures = 0;

    // Reference model state: cycles already spent waiting on the current access, sticky error, counters.
    int accessWaits = 0;
    bit memErr      = 1'b0;
    int stallCnt    = 0;
    int flushCnt    = 0;
    bit prevLU      = 1'b0;
    bit modelValid  = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .idex_memread (idex_memread),
        .idex_rt      (idex_rt),
        .ifid_rs      (ifid_rs),
        .ifid_rt      (ifid_rt),
        .exmem_branch (exmem_branch),
        .exmem_zero   (exmem_zero),
        .exmem_memrd  (exmem_memrd),
        .exmem_memwr  (exmem_memwr),
        .mem_ready    (mem_ready),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
        .memwb_flush  (memwb_flush),
        .pc_src       (pc_src),
        .mem_wait     (mem_wait),
        .mem_err      (mem_err),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFailures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational and registered outputs, then advance the model.
    task automatic applyStimulus(input bit r, input bit ldr, input logic [4:0] irt,
                                 input logic [4:0] rs, input logic [4:0] rt,
                                 input bit br, input bit z, input bit mrd, input bit mwr,
                                 input bit rdy, input string tag);
        bit          memReq, freeze, timeout, branch, lu;
        logic [9:0]  expV, care, obsV;
        rst = r; idex_memread = ldr; idex_rt = irt; ifid_rs = rs; ifid_rt = rt;
        exmem_branch = br; exmem_zero = z; exmem_memrd = mrd; exmem_memwr = mwr; mem_ready = rdy;
        #2;
        memReq  = mrd | mwr;
        freeze  = (accessWaits == 0) ? (memReq && !rdy) : (!rdy && accessWaits < T);
        timeout = (accessWaits > 0) && !rdy && (accessWaits >= T);
        branch  = !freeze && br && z;
        lu      = !freeze && !branch && !prevLU && ldr && (irt != 5'd0) && (irt == rs || irt == rt);
        if (r)           begin expV = 10'b0000000000; care = 10'b1111111111; end
        else if (freeze) begin expV = 10'b0000100010; care = 10'b1111100010; end
        else if (branch) begin expV = 10'b1000111101; care = 10'b1000111101; end
        else if (lu)     begin expV = 10'b0001101000; care = 10'b1101101000; end
        else             begin expV = 10'b1111100000; care = 10'b1111111111; end
        obsV = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush, pc_src};
        checkOutput({tag, ".ctl"}, 32'(obsV & care), 32'(expV & care));
        if (modelValid) begin
            checkOutput({tag, ".mem_wait"}, 32'(mem_wait), 32'(accessWaits > 0));
            checkOutput({tag, ".mem_err"}, 32'(mem_err), 32'(memErr));
            checkOutput({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(stallCnt));
            checkOutput({tag, ".flush_events"}, 32'(flush_events), 32'(flushCnt));
        end
        @(posedge clk);
        if (r) begin
            accessWaits = 0; memErr = 1'b0; stallCnt = 0; flushCnt = 0; prevLU = 1'b0;
            modelValid = 1'b1;
        end else begin
            accessWaits = freeze ? accessWaits + 1 : 0;
            if (timeout) memErr = 1'b1;
            if ((freeze || lu) && stallCnt < CMAX) stallCnt++;
            if (branch && flushCnt < CMAX) flushCnt++;
            prevLU = lu;
        end
        #1;
    endtask

    task automatic idle(input string tag);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        bit rr, ldr, br, z, mrd, mwr, rdy;
        logic [4:0] irt, rs, rt;
        bit holdRd = 1'b0, holdWr = 1'b0;

        #1;
        applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, "reset0");
        applyStimulus(1, 1, 5'd5, 5'd5, 5'd0, 1, 1, 1, 0, 0, "reset1");
        idle("postReset");

        // Load-use on r5, held for a second cycle which must not stall again.
        applyStimulus(0, 1, 5'd5, 5'd5, 5'd2, 0, 0, 0, 0, 1, "loadUse");
        applyStimulus(0, 1, 5'd5, 5'd5, 5'd2, 0, 0, 0, 0, 1, "loadUseDone");
        applyStimulus(0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, 1, "loadUseRt");
        applyStimulus(0, 1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, "loadR0");
        idle("afterLoadR0");

        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, "branchTaken");
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, "branchNotTaken");

        // Three wait cycles, then ready.
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, "memWait");
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 1, "memReady");
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, "zeroWaitStore");
        idle("afterMem");

        // Memory never answers: freeze T cycles, forced release, sticky error.
        for (int i = 0; i < T + 1; i++) applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, "timeout");
        idle("errSticky");
        idle("errSticky2");

        // Load-use and taken branch together: branch wins.
        applyStimulus(0, 1, 5'd3, 5'd3, 5'd3, 1, 1, 0, 0, 0, "luPlusBranch");

        // Deferred branch while frozen, resolved when memory is ready.
        applyStimulus(0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 0, 1, 0, "freezeOverBranch");
        applyStimulus(0, 1, 5'd3, 5'd3, 5'd0, 1, 1, 0, 1, 1, "deferredBranch");

        for (int i = 0; i < 40; i++) applyStimulus(0, 1, 5'd9, 5'd9, 5'd9, 0, 0, 0, 0, 1, "stallSat");
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 1, "flushSat");

        // Reset in the middle of a wait.
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, "enterWait");
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, "inWait");
        applyStimulus(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, "rstInWait");
        idle("afterRstWait");

        for (int n = 0; n < 400; n++) begin
            rr  = ($urandom_range(0, 39) == 0);
            ldr = $urandom_range(0, 1);
            irt = 5'($urandom_range(0, 3));
            rs  = 5'($urandom_range(0, 3));
            rt  = 5'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 2) != 0);
            z   = $urandom_range(0, 1);
            if (accessWaits > 0) begin
                mrd = holdRd; mwr = holdWr; br = 1'b0;
                if ($urandom_range(0, 3) == 0) rdy = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                mrd = $urandom_range(0, 1); mwr = !mrd; br = 1'b0;
            end else begin
                mrd = 1'b0; mwr = 1'b0; br = $urandom_range(0, 1);
            end
            holdRd = mrd; holdWr = mwr;
            applyStimulus(rr, ldr, irt, rs, rt, br, z, mrd, mwr, rdy, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFailures);
        $finish;
    end

endmodule
